// File: rtl/ram_sp_init_if.sv
// Access bus for ram_sp_init: req/ready handshake, byte-enable writes, clear/init status and read return.
interface ram_sp_init_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic                clr;
    logic                req;
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] be;
    logic                ready;
    logic                init_done;
    logic [DATA_W-1:0]   rdata;
    logic                rvalid;

    modport master (
        output clr, req, we, addr, wdata, be,
        input  ready, init_done, rdata, rvalid
    );

    modport slave (
        input  clr, req, we, addr, wdata, be,
        output ready, init_done, rdata, rvalid
    );
endinterface

// File: rtl/ram_sp_init.sv
// Parametrised single-port RAM with byte enables, registered read and a hardware init sweep.
// Define RAM_OUT_REG_EN to add an output register stage (read latency 2 instead of 1).
module ram_sp_init #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 6,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input logic          clk,
    input logic          rst_n,
    ram_sp_init_if.slave bus
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    typedef enum logic {INIT, RUN} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              ready_q;
    logic              init_done_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic accept;
    logic rd_accept;
    logic wr_accept;

    assign accept    = bus.req && ready_q;
    assign rd_accept = accept && !bus.we;
    assign wr_accept = accept && bus.we;

    // The array is not reset; during INIT the sweep owns the single write port.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem[cnt_q] <= INIT_VAL;
        end else if (wr_accept) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (bus.be[i]) begin
                    mem[bus.addr][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rvalid_q <= rd_accept;
            if (rd_accept) begin
                rdata_q <= mem[bus.addr];
            end
            case (state_q)
                INIT: begin
                    if (bus.clr) begin
                        cnt_q <= '0;
                    end else if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q     <= RUN;
                        cnt_q       <= '0;
                        ready_q     <= 1'b1;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    // A request accepted alongside clr still completes; the sweep overwrites it later.
                    if (bus.clr) begin
                        state_q     <= INIT;
                        cnt_q       <= '0;
                        ready_q     <= 1'b0;
                        init_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= INIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.init_done = init_done_q;

`ifdef RAM_OUT_REG_EN
    logic              rvalid_out_q;
    logic [DATA_W-1:0] rdata_out_q;

    // Extra pipeline stage: only rst_n flushes it, clr lets in-flight reads drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_out_q <= 1'b0;
            rdata_out_q  <= '0;
        end else begin
            rvalid_out_q <= rvalid_q;
            rdata_out_q  <= rdata_q;
        end
    end

    assign bus.rvalid = rvalid_out_q;
    assign bus.rdata  = rdata_out_q;
`else
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
`endif
endmodule

// File: tb/tb_ram_sp_init.sv
// Directed bench for ram_sp_init: 8x64 default, 32x16 byte-enable instance, and an INIT_VAL=8'hC3 shadow of the default.
module tb_ram_sp_init;
`ifdef RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst_n;
    int   nChecks = 0;
    int   nFail   = 0;

    ram_sp_init_if #(.DATA_W(8),  .ADDR_W(6)) busA ();
    ram_sp_init_if #(.DATA_W(32), .ADDR_W(4)) busB ();
    ram_sp_init_if #(.DATA_W(8),  .ADDR_W(6)) busC ();

    ram_sp_init #(.DATA_W(8), .ADDR_W(6), .INIT_VAL(8'h00)) dutA (
        .clk(clk), .rst_n(rst_n), .bus(busA)
    );
    ram_sp_init #(.DATA_W(32), .ADDR_W(4), .INIT_VAL(32'h0)) dutB (
        .clk(clk), .rst_n(rst_n), .bus(busB)
    );
    ram_sp_init #(.DATA_W(8), .ADDR_W(6), .INIT_VAL(8'hC3)) dutC (
        .clk(clk), .rst_n(rst_n), .bus(busC)
    );

    // dutC sees exactly the stimulus of dutA so only INIT_VAL differs between them.
    assign busC.clr   = busA.clr;
    assign busC.req   = busA.req;
    assign busC.we    = busA.we;
    assign busC.addr  = busA.addr;
    assign busC.wdata = busA.wdata;
    assign busC.be    = busA.be;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic issueA(input logic w, input logic [5:0] a, input logic [7:0] d);
        busA.req   = 1'b1;
        busA.we    = w;
        busA.addr  = a;
        busA.wdata = d;
        busA.be    = 1'b1;
        @(posedge clk); #1;
        busA.req   = 1'b0;
    endtask

    task automatic issueB(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        busB.req   = 1'b1;
        busB.we    = w;
        busB.addr  = a;
        busB.wdata = d;
        busB.be    = b;
        @(posedge clk); #1;
        busB.req   = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        busA.clr = 0; busA.req = 0; busA.we = 0; busA.addr = '0; busA.wdata = '0; busA.be = 1'b1;
        busB.clr = 0; busB.req = 0; busB.we = 0; busB.addr = '0; busB.wdata = '0; busB.be = '0;
        #1;
        nChecks++; if (busA.ready !== 1'b0) begin nFail++; $display("[TB] FAIL reset_ready: got %b want 0", busA.ready); end
        nChecks++; if (busA.init_done !== 1'b0) begin nFail++; $display("[TB] FAIL reset_init_done: got %b want 0", busA.init_done); end
        nChecks++; if (busA.rvalid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_rvalid: got %b want 0", busA.rvalid); end
        nChecks++; if (busA.rdata !== 8'h00) begin nFail++; $display("[TB] FAIL reset_rdata: got %h want 00", busA.rdata); end
        repeat (3) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        busA.req = 1'b1;
        busA.we  = 1'b0;
        n = 0;
        while (busA.ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        busA.req = 1'b0;
        nChecks++; if (n != 64) begin nFail++; $display("[TB] FAIL init_cycles: got %0d edges want 64", n); end
        nChecks++; if (busA.init_done !== 1'b1) begin nFail++; $display("[TB] FAIL init_done_set: got %b want 1", busA.init_done); end
        nChecks++; if (busB.ready !== 1'b1) begin nFail++; $display("[TB] FAIL wide_ready: got %b want 1", busB.ready); end
    endtask

    task automatic test_init_values();
        logic [5:0] addrs [3];
        addrs[0] = 6'd0; addrs[1] = 6'd37; addrs[2] = 6'd63;
        for (int k = 0; k < 3; k++) begin
            issueA(1'b0, addrs[k], 8'h00);
            repeat (LAT - 1) begin @(posedge clk); #1; end
            nChecks++; if (busA.rvalid !== 1'b1) begin nFail++; $display("[TB] FAIL init_rd_rvalid[%0d]: got %b want 1", addrs[k], busA.rvalid); end
            nChecks++; if (busA.rdata !== 8'h00) begin nFail++; $display("[TB] FAIL init_rd_data[%0d]: got %h want 00", addrs[k], busA.rdata); end
            nChecks++; if (busC.rdata !== 8'hC3) begin nFail++; $display("[TB] FAIL init_c3_data[%0d]: got %h want c3", addrs[k], busC.rdata); end
        end
        @(posedge clk); #1;
        nChecks++; if (busA.rvalid !== 1'b0) begin nFail++; $display("[TB] FAIL init_rd_strobe_len: got %b want 0", busA.rvalid); end
    endtask

    task automatic test_byte_enable();
        issueB(1'b1, 4'd5, 32'hAABBCCDD, 4'b1111);
        nChecks++; if (busB.rvalid !== 1'b0) begin nFail++; $display("[TB] FAIL be_write_no_rvalid: got %b want 0", busB.rvalid); end
        issueB(1'b1, 4'd5, 32'h11223344, 4'b0101);
        issueB(1'b1, 4'd5, 32'hFFFFFFFF, 4'b0000);
        issueB(1'b0, 4'd5, 32'h0, 4'b0000);
        repeat (LAT - 1) begin @(posedge clk); #1; end
        nChecks++; if (busB.rvalid !== 1'b1) begin nFail++; $display("[TB] FAIL be_rvalid: got %b want 1", busB.rvalid); end
        nChecks++; if (busB.rdata !== 32'hAA22CC44) begin nFail++; $display("[TB] FAIL be_rdata: got %h want aa22cc44", busB.rdata); end
        @(posedge clk); #1;
        nChecks++; if (busB.rvalid !== 1'b0) begin nFail++; $display("[TB] FAIL be_rvalid_len: got %b want 0", busB.rvalid); end
        nChecks++; if (busB.rdata !== 32'hAA22CC44) begin nFail++; $display("[TB] FAIL be_rdata_hold: got %h want aa22cc44", busB.rdata); end
    endtask

    task automatic test_back_to_back();
        logic       stW [6];
        logic [5:0] stA [6];
        logic [7:0] stD [6];
        logic [7:0] expD [3];
        int         j;
        logic       expRv;
        stW[0] = 1; stA[0] = 6'd11; stD[0] = 8'h6B;
        stW[1] = 1; stA[1] = 6'd12; stD[1] = 8'h7C;
        stW[2] = 1; stA[2] = 6'd10; stD[2] = 8'h5A;
        stW[3] = 0; stA[3] = 6'd10; stD[3] = 8'h00;
        stW[4] = 0; stA[4] = 6'd11; stD[4] = 8'h00;
        stW[5] = 0; stA[5] = 6'd12; stD[5] = 8'h00;
        expD[0] = 8'h5A; expD[1] = 8'h6B; expD[2] = 8'h7C;
        for (int t = 0; t < 6 + LAT; t++) begin
            if (t < 6) begin
                busA.req = 1'b1; busA.we = stW[t]; busA.addr = stA[t]; busA.wdata = stD[t];
            end else begin
                busA.req = 1'b0;
            end
            @(posedge clk); #1;
            j = t - (LAT - 1);
            expRv = (j >= 3 && j <= 5);
            nChecks++; if (busA.rvalid !== expRv) begin nFail++; $display("[TB] FAIL b2b_rvalid[t=%0d]: got %b want %b", t, busA.rvalid, expRv); end
            if (expRv) begin
                nChecks++; if (busA.rdata !== expD[j-3]) begin nFail++; $display("[TB] FAIL b2b_rdata[t=%0d]: got %h want %h", t, busA.rdata, expD[j-3]); end
                nChecks++; if (busC.rdata !== expD[j-3]) begin nFail++; $display("[TB] FAIL b2b_rdata_c[t=%0d]: got %h want %h", t, busC.rdata, expD[j-3]); end
            end
        end
        busA.req = 1'b0;
    endtask

    task automatic test_clr();
        int n;
        issueA(1'b1, 6'd3, 8'hFF);
        issueA(1'b0, 6'd3, 8'h00);
        repeat (LAT - 1) begin @(posedge clk); #1; end
        nChecks++; if (busA.rdata !== 8'hFF) begin nFail++; $display("[TB] FAIL clr_pre_rdata: got %h want ff", busA.rdata); end
        @(posedge clk); #1;
        busA.clr = 1'b1;
        issueA(1'b0, 6'd3, 8'h00);
        busA.clr = 1'b0;
        nChecks++; if (busA.ready !== 1'b0) begin nFail++; $display("[TB] FAIL clr_ready_drop: got %b want 0", busA.ready); end
        nChecks++; if (busA.init_done !== 1'b0) begin nFail++; $display("[TB] FAIL clr_done_drop: got %b want 0", busA.init_done); end
        repeat (LAT - 1) begin @(posedge clk); #1; end
        nChecks++; if (busA.rvalid !== 1'b1) begin nFail++; $display("[TB] FAIL clr_same_cycle_rvalid: got %b want 1", busA.rvalid); end
        nChecks++; if (busA.rdata !== 8'hFF) begin nFail++; $display("[TB] FAIL clr_same_cycle_rdata: got %h want ff", busA.rdata); end
        n = LAT;
        while (n < 10) begin @(posedge clk); #1; n++; end
        busA.clr = 1'b1;
        @(posedge clk); #1;
        busA.clr = 1'b0;
        n++;
        while (busA.ready !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        nChecks++; if (n != 75) begin nFail++; $display("[TB] FAIL clr_restart_cycles: got %0d edges want 75", n); end
        issueA(1'b0, 6'd3, 8'h00);
        repeat (LAT - 1) begin @(posedge clk); #1; end
        nChecks++; if (busA.rvalid !== 1'b1) begin nFail++; $display("[TB] FAIL clr_post_rvalid: got %b want 1", busA.rvalid); end
        nChecks++; if (busA.rdata !== 8'h00) begin nFail++; $display("[TB] FAIL clr_post_rdata: got %h want 00", busA.rdata); end
        nChecks++; if (busC.rdata !== 8'hC3) begin nFail++; $display("[TB] FAIL clr_post_rdata_c: got %h want c3", busC.rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_read();
        int         n;
        logic       expRv;
        logic [7:0] expD;
        expRv = (LAT == 1);
        expD  = (LAT == 1) ? 8'hA5 : 8'h00;
        issueA(1'b1, 6'd7, 8'hA5);
        issueA(1'b0, 6'd7, 8'h00);
        nChecks++; if (busA.rvalid !== expRv) begin nFail++; $display("[TB] FAIL mid_pre_rvalid: got %b want %b", busA.rvalid, expRv); end
        nChecks++; if (busA.rdata !== expD) begin nFail++; $display("[TB] FAIL mid_pre_rdata: got %h want %h", busA.rdata, expD); end
        rst_n = 1'b0;
        #1;
        nChecks++; if (busA.rvalid !== 1'b0) begin nFail++; $display("[TB] FAIL mid_rst_rvalid: got %b want 0", busA.rvalid); end
        nChecks++; if (busA.rdata !== 8'h00) begin nFail++; $display("[TB] FAIL mid_rst_rdata: got %h want 00", busA.rdata); end
        nChecks++; if (busA.ready !== 1'b0) begin nFail++; $display("[TB] FAIL mid_rst_ready: got %b want 0", busA.ready); end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            nChecks++; if (busA.rvalid !== 1'b0) begin nFail++; $display("[TB] FAIL mid_rst_pending[%0d]: got %b want 0", k, busA.rvalid); end
        end
        rst_n = 1'b1;
        n = 0;
        while (busA.ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        nChecks++; if (n != 64) begin nFail++; $display("[TB] FAIL mid_rst_reinit: got %0d edges want 64", n); end
        issueA(1'b0, 6'd7, 8'h00);
        repeat (LAT - 1) begin @(posedge clk); #1; end
        nChecks++; if (busA.rdata !== 8'h00) begin nFail++; $display("[TB] FAIL mid_rst_post_rdata: got %h want 00", busA.rdata); end
        nChecks++; if (busC.rdata !== 8'hC3) begin nFail++; $display("[TB] FAIL mid_rst_post_rdata_c: got %h want c3", busC.rdata); end
    endtask

    initial begin
        $display("[TB] ram_sp_init bench, read latency %0d", LAT);
        test_reset();
        test_init_values();
        test_byte_enable();
        test_back_to_back();
        test_clr();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
